// File: rtl/srec_arb_pkg.sv
// Shared types and widths for the SREC loader / CPU memory arbiter.
// Optional loader-vs-CPU fairness is enabled by defining SREC_ARB_FAIRNESS_EN.
package srec_arb_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LANES  = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CPU  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] address;
      logic [BYTE_W-1:0] data;
   } fifo_entry_t;

   // One-hot byte lane for a byte offset within a word.
   function automatic logic [LANES-1:0] lane_mask(input logic [1:0] offset);
      return LANES'(1) << offset;
   endfunction

endpackage

// File: rtl/srec_byte_fifo.sv
// Synchronous FIFO of loader {address, byte} entries with show-ahead head output.
// Pointers carry one extra wrap bit to distinguish full from empty.
module srec_byte_fifo
   import srec_arb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        push,
   input  logic        pop,
   input  fifo_entry_t wr_entry,
   output fifo_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   fifo_entry_t storage [FIFO_DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; the pointers alone define validity.
   always_ff @(posedge clock) begin
      if (push) storage[wr_ptr[AW-1:0]] <= wr_entry;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = storage[rd_ptr[AW-1:0]];

endmodule

// File: rtl/srec_mem_arbiter.sv
// Merges the SREC loader byte stream and CPU accesses onto one 32-bit memory write port.
// Define SREC_ARB_FAIRNESS_EN to bound consecutive loader grants while the CPU waits.
module srec_mem_arbiter
   import srec_arb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned IDLE_TIMEOUT = 50000,
   parameter int unsigned FAIR_BURST   = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] ld_address,
   input  logic [BYTE_W-1:0] ld_byte,
   input  logic              ld_write,
   input  logic              ld_error,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [WORD_W-1:0] cpu_address,
   input  logic [WORD_W-1:0] cpu_wdata,
   input  logic [LANES-1:0]  cpu_be,
   output logic              cpu_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [LANES-1:0]  mem_be,
   input  logic              mem_ready,
   output logic              cpu_hold,
   output logic              fifo_overflow
);

   localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

   arb_state_t  state;
   fifo_entry_t ld_entry;
   fifo_entry_t head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   logic        loader_wins;
   logic        cpu_pending;

   logic [IDLE_W-1:0] idle_cnt_q;
   logic [IDLE_W-1:0] idle_cnt_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_address[1:0];

   assign ld_entry = '{address: ld_address, data: ld_byte};

   // cpu_req is still high during the ack cycle; do not re-grant it then.
   assign cpu_pending = cpu_req && !cpu_ack;
   assign fifo_pop    = (state == IDLE) && loader_wins;
   assign fifo_push   = ld_write && (!fifo_full || fifo_pop);

   srec_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .wr_entry (ld_entry),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef SREC_ARB_FAIRNESS_EN
   localparam int unsigned FAIR_W = $clog2(FAIR_BURST + 1);
   localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_BURST);
   localparam logic [FAIR_W-1:0] FAIR_ONE = FAIR_W'(1);

   logic [FAIR_W-1:0] fair_cnt;
   logic              fair_block;
   logic              cpu_grant;

   assign fair_block  = (fair_cnt >= FAIR_MAX) && cpu_pending;
   assign loader_wins = !fifo_empty && !fair_block;
   assign cpu_grant   = (state == IDLE) && !loader_wins && cpu_pending;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fair_cnt <= '0;
      end else if (!cpu_req || cpu_grant) begin
         fair_cnt <= '0;
      end else if (fifo_pop && (fair_cnt != FAIR_MAX)) begin
         fair_cnt <= fair_cnt + FAIR_ONE;
      end
   end
`else
   logic unused_fair;
   assign unused_fair = ^FAIR_BURST;
   assign loader_wins = !fifo_empty;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         cpu_ack     <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (loader_wins) begin
                  state       <= LOAD;
                  mem_req     <= 1'b1;
                  mem_we      <= 1'b1;
                  mem_address <= {head.address[WORD_W-1:2], 2'b00};
                  mem_wdata   <= {LANES{head.data}};
                  mem_be      <= lane_mask(head.address[1:0]);
               end else if (cpu_pending) begin
                  state       <= CPU;
                  mem_req     <= 1'b1;
                  mem_we      <= cpu_we;
                  mem_address <= {cpu_address[WORD_W-1:2], 2'b00};
                  mem_wdata   <= cpu_wdata;
                  mem_be      <= cpu_be;
               end
            end
            LOAD: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            CPU: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  cpu_ack <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (ld_write)                     idle_cnt_d = '0;
      else if (idle_cnt_q != IDLE_MAX)  idle_cnt_d = idle_cnt_q + IDLE_ONE;
   end

   // Hold drops only once the loader has been quiet long enough and all its bytes are written.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt_q    <= '0;
         cpu_hold      <= 1'b1;
         fifo_overflow <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         if (ld_write || ld_error) begin
            cpu_hold <= 1'b1;
         end else if ((idle_cnt_d == IDLE_MAX) && fifo_empty && (state != LOAD)) begin
            cpu_hold <= 1'b0;
         end
         if (ld_write && !fifo_push) fifo_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_srec_mem_arbiter.sv
// Directed self-checking bench for srec_mem_arbiter; honours SREC_ARB_FAIRNESS_EN when defined.
`timescale 1ns/1ps
module tb_srec_mem_arbiter;

   localparam int unsigned FIFO_DEPTH   = 8;
   localparam int unsigned IDLE_TIMEOUT = 10;
   localparam int unsigned FAIR_BURST   = 4;
`ifdef SREC_ARB_FAIRNESS_EN
   localparam int CPU_AFTER = 4;
`else
   localparam int CPU_AFTER = 8;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] ld_address;
   logic [7:0]  ld_byte;
   logic        ld_write;
   logic        ld_error;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_address;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_be;
   logic        cpu_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic        cpu_hold;
   logic        fifo_overflow;

   int errors = 0;
   int checks = 0;

   logic [31:0] acc_addr[$];
   logic [31:0] acc_data[$];
   logic [3:0]  acc_be[$];
   logic        acc_we[$];

   srec_mem_arbiter #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .FAIR_BURST   (FAIR_BURST)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ld_address    (ld_address),
      .ld_byte       (ld_byte),
      .ld_write      (ld_write),
      .ld_error      (ld_error),
      .cpu_req       (cpu_req),
      .cpu_we        (cpu_we),
      .cpu_address   (cpu_address),
      .cpu_wdata     (cpu_wdata),
      .cpu_be        (cpu_be),
      .cpu_ack       (cpu_ack),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_address   (mem_address),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .mem_ready     (mem_ready),
      .cpu_hold      (cpu_hold),
      .fifo_overflow (fifo_overflow)
   );

   always #5 clock = ~clock;

   // Log every accepted memory transfer.
   always @(negedge clock) begin
      if (reset_n && mem_req && mem_ready) begin
         acc_addr.push_back(mem_address);
         acc_data.push_back(mem_wdata);
         acc_be.push_back(mem_be);
         acc_we.push_back(mem_we);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      acc_addr.delete();
      acc_data.delete();
      acc_be.delete();
      acc_we.delete();
   endtask

   task automatic push_byte(input logic [31:0] a, input logic [7:0] b);
      ld_address = a;
      ld_byte    = b;
      ld_write   = 1'b1;
      tick();
      ld_write   = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be: got %b want 0000", mem_be); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
      checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", fifo_overflow); end
      reset_n = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b want 0", mem_req); end
   endtask

   task automatic test_single_byte();
      clear_log();
      mem_ready = 1'b1;
      push_byte(32'h0000_0106, 8'hA5);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_latency1: got %b want 0", mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_latency2: got %b want 1", mem_req); end
      checks++; if (mem_address !== 32'h0000_0104) begin errors++; $display("FAIL single_addr: got %h want 00000104", mem_address); end
      checks++; if (mem_be !== 4'b0100) begin errors++; $display("FAIL single_be: got %b want 0100", mem_be); end
      checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_wdata: got %h want a5a5a5a5", mem_wdata); end
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", mem_we); end
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", mem_req); end
      repeat (3) tick();
      checks++; if (acc_addr.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", acc_addr.size()); end
   endtask

   task automatic test_wait_states();
      int unstable;
      clear_log();
      mem_ready = 1'b0;
      push_byte(32'h0000_0200, 8'h11);
      push_byte(32'h0000_0203, 8'h22);
      checks++;
      if ({mem_req, mem_we, mem_address, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h200, 32'h1111_1111, 4'b0001}) begin
         errors++; $display("FAIL wait_first: got req=%b addr=%h data=%h be=%b want 1 00000200 11111111 0001", mem_req, mem_address, mem_wdata, mem_be);
      end
      unstable = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if ({mem_req, mem_we, mem_address, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h200, 32'h1111_1111, 4'b0001}) unstable++;
      end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL wait_stable: got %0d unstable cycles want 0", unstable); end
      mem_ready = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wait_accept: got %b want 0", mem_req); end
      checks++; if (acc_addr.size() !== 1) begin errors++; $display("FAIL wait_one_xfer: got %0d want 1", acc_addr.size()); end
      tick();
      checks++;
      if ({mem_req, mem_address, mem_wdata, mem_be} !== {1'b1, 32'h200, 32'h2222_2222, 4'b1000}) begin
         errors++; $display("FAIL wait_second: got req=%b addr=%h data=%h be=%b want 1 00000200 22222222 1000", mem_req, mem_address, mem_wdata, mem_be);
      end
      tick();
      checks++; if (acc_addr.size() !== 2) begin errors++; $display("FAIL wait_two_xfer: got %0d want 2", acc_addr.size()); end
   endtask

   task automatic test_boot_hold();
      int drops;
      mem_ready = 1'b1;
      push_byte(32'h0000_0500, 8'h55);
      drops = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (cpu_hold !== 1'b1) drops++;
      end
      checks++; if (drops !== 0) begin errors++; $display("FAIL hold_kept: got %0d early drops want 0", drops); end
      tick();
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_timeout: got %b want 0", cpu_hold); end
      push_byte(32'h0000_0501, 8'h56);
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL hold_reassert: got %b want 1", cpu_hold); end
      ld_error = 1'b1;
      drops = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (cpu_hold !== 1'b1) drops++;
      end
      checks++; if (drops !== 0) begin errors++; $display("FAIL hold_error: got %0d drops want 0", drops); end
      ld_error = 1'b0;
      tick();
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_error_release: got %b want 0", cpu_hold); end
   endtask

   task automatic test_overflow();
      logic [31:0] a;
      logic [7:0]  b;
      int          wait_cnt;
      int          bad;
      clear_log();
      mem_ready   = 1'b0;
      cpu_req     = 1'b1;
      cpu_we      = 1'b0;
      cpu_address = 32'h0000_1003;
      cpu_wdata   = 32'h0;
      cpu_be      = 4'hF;
      tick();
      checks++;
      if ({mem_req, mem_we, mem_address} !== {1'b1, 1'b0, 32'h1000}) begin
         errors++; $display("FAIL ovf_cpu_issue: got req=%b we=%b addr=%h want 1 0 00001000", mem_req, mem_we, mem_address);
      end
      for (int i = 0; i < 9; i++) begin
         a = 32'h300 + 32'(i);
         b = 8'h30 + 8'(i);
         push_byte(a, b);
         if (i == 7) begin
            checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", fifo_overflow); end
         end
      end
      checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", fifo_overflow); end
      mem_ready = 1'b1;
      tick();
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL ovf_cpu_ack: got %b want 1", cpu_ack); end
      cpu_req = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL ovf_ack_pulse: got %b want 0", cpu_ack); end
      wait_cnt = 0;
      while (acc_addr.size() < 9 && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      repeat (6) tick();
      checks++; if (acc_addr.size() !== 9) begin errors++; $display("FAIL ovf_count: got %0d want 9", acc_addr.size()); end
      checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", fifo_overflow); end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         a = 32'h300 + 32'(i);
         b = 8'h30 + 8'(i);
         if (acc_addr.size() < i + 2) bad++;
         else if ({acc_addr[i+1], acc_data[i+1], acc_be[i+1], acc_we[i+1]} !==
                  {a[31:2], 2'b00, {4{b}}, 4'b0001 << a[1:0], 1'b1}) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_order: got %0d bad entries want 0", bad); end
   endtask

   task automatic test_fairness();
      logic [31:0] a;
      logic [7:0]  b;
      int          wait_cnt;
      int          cpu_idx;
      int          j;
      int          bad;
      logic        got_ack;
      clear_log();
      mem_ready   = 1'b1;
      cpu_we      = 1'b1;
      cpu_address = 32'h0000_2000;
      cpu_wdata   = 32'hDEAD_BEEF;
      cpu_be      = 4'hF;
      for (int i = 0; i < 8; i++) begin
         a = 32'h400 + 32'(i);
         b = 8'h40 + 8'(i);
         push_byte(a, b);
         if (i == 0) cpu_req = 1'b1;
      end
      got_ack  = 1'b0;
      wait_cnt = 0;
      while (!got_ack && wait_cnt < 60) begin
         tick();
         wait_cnt++;
         if (cpu_ack === 1'b1) got_ack = 1'b1;
      end
      cpu_req = 1'b0;
      checks++; if (got_ack !== 1'b1) begin errors++; $display("FAIL fair_ack: got %b want 1", got_ack); end
      repeat (20) tick();
      checks++; if (acc_addr.size() !== 9) begin errors++; $display("FAIL fair_count: got %0d want 9", acc_addr.size()); end
      cpu_idx = -1;
      for (int i = 0; i < acc_addr.size(); i++) if (acc_addr[i] === 32'h2000) cpu_idx = i;
      checks++; if (cpu_idx !== CPU_AFTER) begin errors++; $display("FAIL fair_cpu_slot: got %0d want %0d", cpu_idx, CPU_AFTER); end
      if (cpu_idx >= 0) begin
         checks++;
         if ({acc_we[cpu_idx], acc_data[cpu_idx], acc_be[cpu_idx]} !== {1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL fair_cpu_fields: got we=%b data=%h be=%b want 1 deadbeef 1111", acc_we[cpu_idx], acc_data[cpu_idx], acc_be[cpu_idx]);
         end
      end
      bad = 0;
      j = 0;
      for (int i = 0; i < acc_addr.size(); i++) begin
         if (i != cpu_idx) begin
            a = 32'h400 + 32'(j);
            b = 8'h40 + 8'(j);
            if ({acc_addr[i], acc_data[i], acc_be[i]} !== {a[31:2], 2'b00, {4{b}}, 4'b0001 << a[1:0]}) bad++;
            j++;
         end
      end
      checks++; if (bad !== 0 || j !== 8) begin errors++; $display("FAIL fair_loader_order: got %0d bad of %0d want 0 of 8", bad, j); end
   endtask

   task automatic test_reset_mid();
      mem_ready = 1'b0;
      push_byte(32'h0000_0600, 8'h66);
      push_byte(32'h0000_0604, 8'h77);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", mem_req); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_address, mem_wdata, mem_be, cpu_ack, cpu_hold, fifo_overflow} !==
          {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rst_mid_outputs: got req=%b we=%b addr=%h data=%h be=%b ack=%b hold=%b ovf=%b want 0 0 0 0 0 0 1 0",
                            mem_req, mem_we, mem_address, mem_wdata, mem_be, cpu_ack, cpu_hold, fifo_overflow);
      end
      tick();
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      clear_log();
      repeat (6) tick();
      checks++; if (acc_addr.size() !== 0) begin errors++; $display("FAIL rst_mid_fifo_empty: got %0d xfers want 0", acc_addr.size()); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b want 0", mem_req); end
   endtask

   initial begin
      reset_n     = 1'b0;
      ld_address  = '0;
      ld_byte     = '0;
      ld_write    = 1'b0;
      ld_error    = 1'b0;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_address = '0;
      cpu_wdata   = '0;
      cpu_be      = '0;
      mem_ready   = 1'b0;
      test_reset();
      test_single_byte();
      test_wait_states();
      test_boot_hold();
      test_overflow();
      test_fairness();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
